apb_cmd_initiator: RTL and testbench



---
 rtl/apb_cmd_initiator.sv | 183 ++++++++++++++++++
 tb/tb_apb_cmd_initiator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_initiator.sv
// apb_cmd_initiator
// Converts ready/valid register commands into single APB transfers and
// returns read data / error status on a ready/valid response channel.
// One transfer is outstanding at a time: IDLE -> SETUP -> ACCESS -> RESP.
//
// Optional build macro APB_INIT_TIMEOUT_EN adds an ACCESS-phase watchdog
// that aborts a transfer after TIMEOUT cycles without pready.
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// vld and rdy are both high; the sender holds vld and payload until then.
module apb_cmd_initiator #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // A zero or negative limit would make the watchdog meaningless.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_cmd_initiator: TIMEOUT must be at least 1");
    end

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              cmd_fire;
    logic              rsp_fire;
    logic              access_done;
    logic              access_timeout;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    // Command acceptance is blocked while reset is held so that cmd_rdy
    // reads 0 during reset even once the state register is in IDLE.
    assign cmd_rdy     = (state == ST_IDLE) && !rst;
    assign psel        = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable     = (state == ST_ACCESS);
    assign rsp_vld     = (state == ST_RESP);
    assign cmd_fire    = cmd_vld && cmd_rdy;
    assign rsp_fire    = rsp_vld && rsp_rdy;
    // pready / pslverr only matter during ACCESS.
    assign access_done = (state == ST_ACCESS) && pready;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;

`ifdef APB_INIT_TIMEOUT_EN
    // Counter is at least 8 bits wide even for small limits.
    localparam int CNT_BITS = $clog2(TIMEOUT + 1);
    localparam int CNT_W    = (CNT_BITS < 8) ? 8 : CNT_BITS;
    // The abort fires in the cycle whose increment would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             to_q;

    // Count ACCESS cycles spent without pready; cleared while in SETUP.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A pready arriving in the limit cycle takes priority over the abort.
    assign access_timeout = (state == ST_ACCESS) && !pready && (wait_cnt == CNT_LIMIT);

    // Timeout flag of the response; cleared once the response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= 1'b0;
        end else if (access_done) begin
            to_q <= 1'b0;
        end else if (access_timeout) begin
            to_q <= 1'b1;
        end else if (rsp_fire) begin
            to_q <= 1'b0;
        end
    end

    assign rsp_timeout = to_q;
`else
    // Without the watchdog, ACCESS waits for pready forever.
    assign access_timeout = 1'b0;
    assign rsp_timeout    = 1'b0;
`endif

    // Next-state selection for the transfer sequencer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (access_done || access_timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; reset from any state drops the transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the accepted command; the APB address/data bus holds it until
    // the next command is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
        end else if (cmd_fire) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
        end
    end

    // Response capture: read data only for error-free reads, zero otherwise;
    // the fields are cleared once the response has been handed off.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access_done) begin
            rdata_q <= (pwrite || pslverr) ? '0 : prdata;
            err_q   <= pslverr;
        end else if (access_timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (rsp_fire) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Bench for apb_cmd_initiator: directed vector table, randomized transfers
// checked against a response model, and hand-written reset sequences.
// Honours APB_INIT_TIMEOUT_EN when it is defined for the build.
module tb_apb_cmd_initiator;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk;
  logic          rst;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prd;
    logic          slverr;
    int            rdly;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  apb_cmd_initiator #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  // clock / time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // response model: what the transfer should return
  function automatic logic model_to(input int waits);
`ifdef APB_INIT_TIMEOUT_EN
    return (waits >= TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] model_rdata(input logic w, input logic se, input logic to,
                                                 input logic [DW-1:0] prd);
    if (w || se || to) return '0;
    return prd;
  endfunction

  function automatic logic model_err(input logic se, input logic to);
    return to ? 1'b1 : se;
  endfunction

  // One complete command: issue, APB phases with `waits` wait states,
  // response held for `rdly` cycles, then handshake.
  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic [DW-1:0] prd, input logic se,
                         input int rdly, input logic [DW-1:0] er, input logic ee,
                         input logic eto);
    int n;
    int acc_len;
    cmd_vld   = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    chk("cmd_rdy_idle", cmd_rdy, 1);
    n = 0;
    while (!cmd_rdy && n < 20) begin
      step();
      n++;
    end
    step();
    // scramble the command inputs: the DUT must use its latched copy
    cmd_vld   = 1'b0;
    cmd_write = ~w;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_cmd_rdy", cmd_rdy, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    chk("setup_pwdata", pwdata, d);
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    step();
    acc_len = eto ? TMO : waits + 1;
    for (int c = 0; c < acc_len; c++) begin
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_rsp_vld", rsp_vld, 0);
      chk("access_paddr", paddr, a);
      chk("access_pwrite", pwrite, w);
      chk("access_pwdata", pwdata, d);
      pready  = (c == waits);
      prdata  = (c == waits) ? prd : DW'($urandom);
      pslverr = (c == waits) ? se : 1'($urandom);
      step();
    end
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    chk("resp_vld", rsp_vld, 1);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    chk("resp_rdata", rsp_rdata, er);
    chk("resp_err", rsp_err, ee);
    chk("resp_timeout", rsp_timeout, eto);
    for (int h = 0; h < rdly; h++) begin
      rsp_rdy = 1'b0;
      cmd_vld = 1'b1;
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
      step();
      chk("hold_rsp_vld", rsp_vld, 1);
      chk("hold_cmd_rdy", cmd_rdy, 0);
      chk("hold_psel", psel, 0);
      chk("hold_rdata", rsp_rdata, er);
      chk("hold_err", rsp_err, ee);
      chk("hold_timeout", rsp_timeout, eto);
    end
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    cmd_vld = 1'b0;
    pready  = 1'b0;
    chk("post_rsp_vld", rsp_vld, 0);
    chk("post_cmd_rdy", cmd_rdy, 1);
  endtask

  initial begin
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] prd;
    logic          se;
    logic          to;
    int            waits;

    rst       = 1'b1;
    cmd_vld   = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_rdy   = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    // reset state
    step();
    step();
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;
    step();
    chk("post_rst_cmd_rdy", cmd_rdy, 1);

    // directed vector table
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1'b0, 0,  32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h24, 32'h0,        3, 32'h12345678, 1'b0, 0,  32'h12345678, 1'b0};
    vecs[2] = '{1'b0, 32'h28, 32'h0,        1, 32'h0000FFFF, 1'b1, 1,  32'h0,        1'b1};
    vecs[3] = '{1'b1, 32'h2C, 32'h55AA55AA, 2, 32'h11111111, 1'b1, 0,  32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'h40, 32'h0,        0, 32'hA5A5A5A5, 1'b0, 10, 32'hA5A5A5A5, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, 0, 32'h0,  1'b0, 0,  32'h0,        1'b0};
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].prd,
              vecs[i].slverr, vecs[i].rdly, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
    end

    // long stall: aborted after TMO cycles with the watchdog, otherwise
    // ACCESS lasts the full 120 wait states
    to = model_to(120);
    run_txn(1'b0, 32'h30, 32'h0, 120, 32'hCAFEF00D, 1'b0, 0,
            model_rdata(1'b0, 1'b0, to, 32'hCAFEF00D), model_err(1'b0, to), to);
    // pready in the limit cycle completes normally
    to = model_to(TMO - 1);
    run_txn(1'b0, 32'h34, 32'h0, TMO - 1, 32'h0BADCAFE, 1'b0, 0,
            model_rdata(1'b0, 1'b0, to, 32'h0BADCAFE), model_err(1'b0, to), to);

    // randomized transfers through the response model and expected queue
    for (int i = 0; i < 60; i++) begin
      w     = 1'($urandom);
      a     = $urandom & 32'hFFFF_FFFC;
      d     = $urandom;
      prd   = $urandom;
      se    = ($urandom_range(0, 3) == 0);
      waits = $urandom_range(0, 5);
      to    = model_to(waits);
      exp_q.push_back(model_rdata(w, se, to, prd));
      run_txn(w, a, d, waits, prd, se, $urandom_range(0, 3), exp_q.pop_front(),
              model_err(se, to), to);
    end

    // reset during ACCESS drops the transfer without a response
    cmd_vld   = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h44;
    step();
    cmd_vld = 1'b0;
    pready  = 1'b0;
    step();
    chk("mid_access_penable", penable, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_vld", rsp_vld, 0);
    chk("mid_rst_cmd_rdy", cmd_rdy, 0);
    chk("mid_rst_paddr", paddr, 0);
    rst = 1'b0;
    step();
    chk("mid_rst_release_cmd_rdy", cmd_rdy, 1);
    for (int c = 0; c < 8; c++) begin
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      rsp_rdy = 1'($urandom);
      step();
      chk("dropped_rsp_vld", rsp_vld, 0);
      chk("dropped_psel", psel, 0);
    end
    rsp_rdy = 1'b0;
    pready  = 1'b0;

    // the block still works after the aborted transfer
    run_txn(1'b0, 32'h48, 32'h0, 0, 32'h600DD00D, 1'b0, 0, 32'h600DD00D, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
